glb_port_arbiter: RTL and testbench

//  Shares one single-ported GLB SRAM port between four requesters: DRAM loader (wr), array fetch (rd),

---
 rtl/glb_pkg.sv | 21 ++
 rtl/glb_port_arbiter_rr_pick.sv | 37 +++
 rtl/glb_port_arbiter.sv | 119 +++++++++++
 tb/tb_glb_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared GLB definitions: requester ids and default port geometry used by
// every bank-side arbiter instance.
package glb_pkg;

  localparam int GLB_ADDR_W    = 12;
  localparam int GLB_N_REQ     = 4;
  localparam int GLB_MAX_BURST = 16;

  typedef enum logic [1:0] {
    REQ_DRAM  = 2'd0,
    REQ_ARRAY = 2'd1,
    REQ_OFMAP = 2'd2,
    REQ_PPU   = 2'd3
  } req_id_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request found when scanning
// upward from start, wrapping modulo N.
module rr_pick
  import glb_pkg::*;
#(
  parameter  int N    = GLB_N_REQ,
  localparam int ID_W = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] index,
  output logic            found
);

  int              sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(start) + i;
      if (sum >= N) sum = sum - N;
      idx = ID_W'(sum);
      if (!found && req[idx]) begin
        found       = 1'b1;
        index       = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// Single-port GLB bank arbiter: round-robin between requesters with a
// bounded burst lock, plus read-valid strobes aligned to the SRAM latency.
module glb_port_arbiter
  import glb_pkg::*;
#(
  parameter  int N_REQ     = GLB_N_REQ,
  parameter  int ADDR_W    = GLB_ADDR_W,
  parameter  int MAX_BURST = GLB_MAX_BURST,
  localparam int ID_W      = idx_w(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  owner;
  logic             owned;
  logic [CNT_W-1:0] burst_cnt;

  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;

  logic             keep;
  logic             any_gnt;
  logic [ID_W-1:0]  win;

  logic [ID_W-1:0]  next_ptr;
  logic [ID_W-1:0]  next_owner;
  logic             next_owned;
  logic [CNT_W-1:0] next_cnt;

  logic [ADDR_W-1:0] addr_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_addr
    assign addr_arr[i] = addr[i*ADDR_W +: ADDR_W];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .start  (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .found  (pick_found)
  );

  // A held lock beats round-robin only while the owner still requests and
  // has burst budget left; otherwise the scan restarts after the last winner.
  assign keep = owned && req[owner] && (burst_cnt < CNT_W'(MAX_BURST));

  always_comb begin
    gnt     = '0;
    win     = '0;
    any_gnt = 1'b0;
    if (!rst) begin
      if (keep) begin
        gnt[owner] = 1'b1;
        win        = owner;
        any_gnt    = 1'b1;
      end else if (pick_found) begin
        gnt     = pick_onehot;
        win     = pick_idx;
        any_gnt = 1'b1;
      end
    end
  end

  assign sram_en   = any_gnt;
  assign sram_we   = any_gnt & we[win];
  assign sram_addr = any_gnt ? addr_arr[win] : '0;
  assign grant_id  = win;

  always_comb begin
    next_ptr   = rr_ptr;
    next_owner = owner;
    next_owned = 1'b0;
    next_cnt   = '0;
    if (any_gnt) begin
      next_ptr = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
      if (lock[win]) begin
        next_owned = 1'b1;
        next_owner = win;
        next_cnt   = keep ? burst_cnt + CNT_W'(1) : CNT_W'(1);
      end
    end
  end

  // Reset also drops any read strobe that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      owned     <= 1'b0;
      burst_cnt <= '0;
      rvalid    <= '0;
      busy      <= 1'b0;
    end else begin
      rr_ptr    <= next_ptr;
      owner     <= next_owner;
      owned     <= next_owned;
      burst_cnt <= next_cnt;
      rvalid    <= gnt & ~we;
      busy      <= next_owned;
    end
  end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Self-checking bench for glb_port_arbiter: a per-cycle behavioural model
// plus directed scenarios with hand-computed grant sequences.
module tb_glb_port_arbiter;
  import glb_pkg::*;

  localparam int N  = GLB_N_REQ;
  localparam int AW = GLB_ADDR_W;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt, rvalid;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Per-cycle logs taken at each falling edge: granted id (-1 idle), busy, rvalid.
  int dq[$];
  int bq[$];
  int rq[$];

  // Model state, held as plain integers.
  int         m_ptr   = 0;
  int         m_owner = 0;
  int         m_cnt   = 0;
  bit         m_owned = 1'b0;
  bit         m_busy  = 1'b0;
  logic [N-1:0] m_rvalid = '0;

  int e2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int e4[5] = '{2, 2, 2, 3, 3};

  always #5 clk = ~clk;

  glb_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] w, input int cycles);
    req  = r;
    lock = l;
    we   = w;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    dq.delete();
    bq.delete();
    rq.delete();
  endtask

  // Model + compare: decide the grant from the arbitration rules, check every
  // output, then advance the model as the next rising edge will.
  initial begin
    int          g;
    bit          case_a;
    logic [N-1:0] eg;
    int          j;
    forever begin
      @(negedge clk);
      g = -1;
      case_a = 1'b0;
      if (!rst) begin
        if (m_owned && req[m_owner] && m_cnt < MB) begin
          g = m_owner;
          case_a = 1'b1;
        end else begin
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && req[j]) g = j;
          end
        end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;

      checkOutput("gnt", gnt, eg);
      checkOutput("sram_en", sram_en, (g >= 0));
      checkOutput("sram_we", sram_we, (g >= 0) ? we[g] : 1'b0);
      checkOutput("sram_addr", sram_addr, (g >= 0) ? addr[g*AW +: AW] : '0);
      checkOutput("grant_id", grant_id, (g >= 0) ? g : 0);
      checkOutput("rvalid", rvalid, m_rvalid);
      checkOutput("busy", busy, m_busy);

      dq.push_back(sram_en ? int'(grant_id) : -1);
      bq.push_back(int'(busy));
      rq.push_back(int'(rvalid));

      if (rst) begin
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_owned = 1'b0;
        m_rvalid = '0; m_busy = 1'b0;
      end else begin
        m_rvalid = '0;
        if (g >= 0 && !we[g]) m_rvalid[g] = 1'b1;
        if (g < 0) begin
          m_owned = 1'b0;
          m_cnt = 0;
        end else begin
          m_ptr = (g + 1) % N;
          if (lock[g]) begin
            m_cnt = case_a ? m_cnt + 1 : 1;
            m_owned = 1'b1;
            m_owner = g;
          end else begin
            m_owned = 1'b0;
            m_cnt = 0;
          end
        end
        m_busy = m_owned;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    lock = '0;
    we   = '0;
    addr = {12'h3C3, 12'h2B2, 12'h1A1, 12'h090};

    $display("[TB] reset with all requests pending");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", gnt, 4'b0000);
    checkOutput("reset_en", sram_en, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearLogs();

    $display("[TB] round-robin fairness");
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rr_seq_%0d", i), dq[i], e2[i]);
    checkOutput("first_rvalid", rq[0], 0);
    checkOutput("rvalid_lag", rq[1], 1);
    checkOutput("rvalid_lag2", rq[2], 2);

    $display("[TB] burst lock bounded by max burst");
    clearLogs();
    applyStimulus(4'b0011, 4'b0001, 4'b0001, 18);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("burst_%0d", i), dq[i], 0);
    checkOutput("burst_yield", dq[16], 1);
    checkOutput("burst_back", dq[17], 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1);

    $display("[TB] lock release by owner dropping req");
    clearLogs();
    applyStimulus(4'b1100, 4'b0100, 4'b0000, 3);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 2);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("release_%0d", i), dq[i], e4[i]);
    checkOutput("busy_held", bq[3], 1);
    checkOutput("busy_fall", bq[4], 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1);

    $display("[TB] solo locked requester re-wins");
    clearLogs();
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 40);
    for (int i = 0; i < 40; i++) checkOutput($sformatf("solo_%0d", i), dq[i], 0);
    checkOutput("solo_busy", bq[39], 1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1);

    $display("[TB] reset in the middle of a burst");
    clearLogs();
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("pre_rst_%0d", i), dq[i], 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_gnt", gnt, 4'b0000);
    checkOutput("mid_rst_busy", busy, 1'b1);
    checkOutput("mid_rst_rvalid", rvalid, 4'b0010);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req  = 4'b1001;
    lock = 4'b0000;
    we   = 4'b0000;
    @(negedge clk);
    checkOutput("post_rst_rvalid", rvalid, 4'b0000);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_gnt", gnt, 4'b0001);
    checkOutput("post_rst_id", grant_id, 0);
    @(negedge clk);
    checkOutput("post_rst_next", grant_id, 3);
    checkOutput("post_rst_rv", rvalid, 4'b0001);
    @(posedge clk);
    #1;
    req = 4'b0000;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
